// File: rtl/dlx_ctrl_pkg.sv
// Shared types and constants for the DLX step/run execution controller.
package dlx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RUN   = 3'd4,
        ST_STOP  = 3'd5
    } step_state_e;

    localparam logic [11:0] FETCH_STATE_DEF = 12'h001;
    localparam logic [11:0] HALT_STATE_DEF  = 12'h800;
    localparam int          STEP_CNT_W      = 16;

endpackage

// File: rtl/dlx_step_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge pulse for one
// asynchronous button/switch input.
module dlx_step_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // Synchronise, then accept a new level only after DEB_CYC equal samples;
    // the down-counter reloads whenever the sample matches the held level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                cnt_q   <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/dlx_step_ctrl.sv
// Execution controller for the IO-simulated DLX core: init window, single
// step per button press, free-run with optional PC breakpoint, halt and
// instruction-timeout detection.
// Optional breakpoint compare is built when DLX_STEP_BP_EN is defined.
//
// state | meaning
// INIT  | post-reset initialisation window, IN_INIT high
// IDLE  | waiting for a step trigger or the run switch
// ISSUE | first cycle of a single-stepped instruction
// BUSY  | single-stepped instruction in flight
// RUN   | free-running, one instruction after another
// STOP  | stopped on breakpoint, halt or timeout
module dlx_step_ctrl
    import dlx_ctrl_pkg::*;
#(
    parameter int                 STATE_W     = 12,
    parameter int                 PC_W        = 32,
    parameter logic [STATE_W-1:0] FETCH_STATE = FETCH_STATE_DEF,
    parameter logic [STATE_W-1:0] HALT_STATE  = HALT_STATE_DEF,
    parameter int                 INIT_CYC    = 8,
    parameter int                 DEB_CYC     = 4,
    parameter int                 TIMEOUT_CYC = 1024
) (
    input  logic                  CLK_IN,
    input  logic                  RESET_IN,
    input  logic                  STEP_IN,
    input  logic                  RUN_IN,
    input  logic [STATE_W-1:0]    STATE,
    input  logic [PC_W-1:0]       PC,
    input  logic [PC_W-1:0]       BP_ADDR,
    input  logic                  BP_VALID,
    output logic                  STEP_EN,
    output logic                  IN_INIT,
    output logic                  HALTED,
    output logic                  BRK,
    output logic                  ERR,
    output logic [STEP_CNT_W-1:0] STEP_CNT
);

    localparam int IC_W = $clog2(INIT_CYC + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IC_W-1:0] INIT_LOAD = IC_W'(INIT_CYC - 1);
    localparam logic [TW-1:0]   TMO_LOAD  = TW'(TIMEOUT_CYC);

    step_state_e           state_q;
    logic [IC_W-1:0]       init_cnt_q;
    logic [TW-1:0]         tmo_q;
    logic                  seen_leave_q;
    logic                  skip_bp_q;
    logic                  step_en_q;
    logic                  in_init_q;
    logic                  halted_q;
    logic                  brk_q;
    logic                  err_q;
    logic [STEP_CNT_W-1:0] step_cnt_q;

    logic step_lvl;
    logic step_rise;
    logic run_lvl;
    logic run_rise;
    logic is_fetch;
    logic is_halt;
    logic complete;
    logic bp_hit;

    dlx_step_debounce #(.DEB_CYC(DEB_CYC)) u_step_deb (
        .clk_i   (CLK_IN),
        .rst_i   (RESET_IN),
        .din_i   (STEP_IN),
        .level_o (step_lvl),
        .rise_o  (step_rise)
    );

    dlx_step_debounce #(.DEB_CYC(DEB_CYC)) u_run_deb (
        .clk_i   (CLK_IN),
        .rst_i   (RESET_IN),
        .din_i   (RUN_IN),
        .level_o (run_lvl),
        .rise_o  (run_rise)
    );

    assign is_fetch = (STATE == FETCH_STATE);
    assign is_halt  = (STATE == HALT_STATE);
    assign complete = is_fetch && seen_leave_q;

`ifdef DLX_STEP_BP_EN
    // The first completion after leaving a breakpoint stop is never re-checked.
    assign bp_hit = BP_VALID && (PC == BP_ADDR) && !skip_bp_q;
    assign BRK    = brk_q;

    logic unused_sig;
    assign unused_sig = ^{step_lvl, run_rise};
`else
    assign bp_hit = 1'b0;
    assign BRK    = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{step_lvl, run_rise, PC, BP_ADDR, BP_VALID, skip_bp_q, brk_q};
`endif

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= INIT_LOAD;
            tmo_q        <= '0;
            seen_leave_q <= 1'b0;
            skip_bp_q    <= 1'b0;
            step_en_q    <= 1'b0;
            in_init_q    <= 1'b1;
            halted_q     <= 1'b0;
            brk_q        <= 1'b0;
            err_q        <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == '0) begin
                        state_q   <= ST_IDLE;
                        in_init_q <= 1'b0;
                    end else begin
                        init_cnt_q <= init_cnt_q - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (run_lvl) begin
                        state_q      <= ST_RUN;
                        step_en_q    <= 1'b1;
                        tmo_q        <= TMO_LOAD;
                        seen_leave_q <= 1'b0;
                    end else if (step_rise) begin
                        state_q      <= ST_ISSUE;
                        step_en_q    <= 1'b1;
                        tmo_q        <= TMO_LOAD;
                        seen_leave_q <= 1'b0;
                    end
                end
                ST_ISSUE, ST_BUSY, ST_RUN: begin
                    if (is_halt) begin
                        state_q   <= ST_STOP;
                        step_en_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else if (tmo_q == '0) begin
                        state_q   <= ST_STOP;
                        step_en_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                        if (!is_fetch) begin
                            seen_leave_q <= 1'b1;
                        end
                        if (state_q == ST_ISSUE) begin
                            state_q <= ST_BUSY;
                        end else if (complete) begin
                            step_cnt_q   <= step_cnt_q + 1'b1;
                            seen_leave_q <= 1'b0;
                            skip_bp_q    <= 1'b0;
                            tmo_q        <= TMO_LOAD;
                            if (state_q == ST_RUN && bp_hit) begin
                                state_q   <= ST_STOP;
                                step_en_q <= 1'b0;
                                brk_q     <= 1'b1;
                            end else if (state_q == ST_BUSY || !run_lvl) begin
                                state_q   <= ST_IDLE;
                                step_en_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    // Halt and timeout stops are terminal until reset.
                    if (step_rise && !halted_q && !err_q) begin
                        state_q      <= ST_ISSUE;
                        step_en_q    <= 1'b1;
                        skip_bp_q    <= brk_q;
                        brk_q        <= 1'b0;
                        tmo_q        <= TMO_LOAD;
                        seen_leave_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign STEP_EN  = step_en_q;
    assign IN_INIT  = in_init_q;
    assign HALTED   = halted_q;
    assign ERR      = err_q;
    assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_dlx_step_ctrl.sv
// Self-checking bench for dlx_step_ctrl with a tiny behavioural DLX core
// (FETCH -> 002 -> 004 -> FETCH, PC += 4 per instruction).
module tb_dlx_step_ctrl;

    logic        CLK_IN = 1'b0;
    logic        RESET_IN;
    logic        STEP_IN;
    logic        RUN_IN;
    logic [11:0] STATE;
    logic [31:0] PC;
    logic [31:0] BP_ADDR;
    logic        BP_VALID;
    logic        STEP_EN;
    logic        IN_INIT;
    logic        HALTED;
    logic        BRK;
    logic        ERR;
    logic [15:0] STEP_CNT;

    logic [11:0] core_state;
    logic [31:0] core_pc;
    int          core_done;
    logic        force_en;
    logic [11:0] force_state;

    int n_chk  = 0;
    int n_fail = 0;

    assign STATE = force_en ? force_state : core_state;
    assign PC    = core_pc;

    always #5 CLK_IN = ~CLK_IN;

    dlx_step_ctrl dut (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .STEP_IN  (STEP_IN),
        .RUN_IN   (RUN_IN),
        .STATE    (STATE),
        .PC       (PC),
        .BP_ADDR  (BP_ADDR),
        .BP_VALID (BP_VALID),
        .STEP_EN  (STEP_EN),
        .IN_INIT  (IN_INIT),
        .HALTED   (HALTED),
        .BRK      (BRK),
        .ERR      (ERR),
        .STEP_CNT (STEP_CNT)
    );

    typedef struct {
        int len;
        int exp_windows;
        int exp_lat;
        int exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, where the core model
    // also advances one micro-state whenever STEP_EN is high.
    task automatic tick();
        @(negedge CLK_IN);
        if (!force_en && STEP_EN === 1'b1) begin
            case (core_state)
                12'h001: core_state = 12'h002;
                12'h002: core_state = 12'h004;
                default: begin
                    core_state = 12'h001;
                    core_pc    = core_pc + 32'd4;
                    core_done++;
                end
            endcase
        end
    endtask

    task automatic press(input int len);
        STEP_IN = 1'b1;
        repeat (len) tick();
        STEP_IN = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_step_en"}, 32'(STEP_EN), 32'd0);
        chk({tag, "_in_init"}, 32'(IN_INIT), 32'd1);
        chk({tag, "_halted"},  32'(HALTED),  32'd0);
        chk({tag, "_brk"},     32'(BRK),     32'd0);
        chk({tag, "_err"},     32'(ERR),     32'd0);
        chk({tag, "_cnt"},     32'(STEP_CNT), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        int hi;
        force_en   = 1'b0;
        STEP_IN    = 1'b0;
        RUN_IN     = 1'b0;
        RESET_IN   = 1'b1;
        core_state = 12'h001;
        core_pc    = 32'd0;
        core_done  = 0;
        repeat (4) tick();
        RESET_IN = 1'b0;
        chk_reset_vals(tag);
        hi = 0;
        for (int i = 0; i < 40 && IN_INIT === 1'b1; i++) begin
            hi++;
            tick();
        end
        chk({tag, "_init_len"}, 32'(hi), 32'd8);
    endtask

    initial begin
        int win;
        int lat;
        int hi_cnt;
        logic prev;

        vecs[0] = '{len: 1, exp_windows: 0, exp_lat: -1, exp_cnt: 0};
        vecs[1] = '{len: 2, exp_windows: 0, exp_lat: -1, exp_cnt: 0};
        vecs[2] = '{len: 3, exp_windows: 0, exp_lat: -1, exp_cnt: 0};
        vecs[3] = '{len: 4, exp_windows: 1, exp_lat: 7,  exp_cnt: 1};
        vecs[4] = '{len: 6, exp_windows: 1, exp_lat: 7,  exp_cnt: 2};
        vecs[5] = '{len: 9, exp_windows: 1, exp_lat: 7,  exp_cnt: 3};

        BP_ADDR     = 32'h10;
        BP_VALID    = 1'b1;
        force_state = 12'h001;
        do_reset("rst0");

        // Step presses of various lengths: glitches ignored, 4+ samples step once.
        for (int v = 0; v < 6; v++) begin
            win  = 0;
            lat  = -1;
            prev = 1'b0;
            STEP_IN = 1'b1;
            for (int t = 1; t <= 30; t++) begin
                tick();
                if (t == vecs[v].len) STEP_IN = 1'b0;
                if (STEP_EN === 1'b1 && !prev) begin
                    win++;
                    if (lat < 0) lat = t;
                end
                prev = STEP_EN;
            end
            chk($sformatf("vec%0d_windows", v), 32'(win), 32'(vecs[v].exp_windows));
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("vec%0d_cnt", v), 32'(STEP_CNT), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_pc", v), core_pc, 32'(vecs[v].exp_cnt * 4));
        end

        // Free-run towards the breakpoint.
        do_reset("rst1");
        RUN_IN = 1'b1;
`ifdef DLX_STEP_BP_EN
        for (int i = 0; i < 200 && BRK !== 1'b1; i++) tick();
        chk("bp_brk", 32'(BRK), 32'd1);
        chk("bp_pc", core_pc, 32'h10);
        chk("bp_cnt", 32'(STEP_CNT), 32'd4);
        chk("bp_step_en", 32'(STEP_EN), 32'd0);
        chk("bp_core_fetch", 32'(core_state), 32'h001);
        RUN_IN = 1'b0;
        repeat (12) tick();
        press(5);
        repeat (25) tick();
        chk("bp_step_brk", 32'(BRK), 32'd0);
        chk("bp_step_cnt", 32'(STEP_CNT), 32'd5);
        chk("bp_step_pc", core_pc, 32'h14);
        chk("bp_step_en_off", 32'(STEP_EN), 32'd0);
`else
        repeat (60) tick();
        chk("run_brk", 32'(BRK), 32'd0);
        chk("run_step_en", 32'(STEP_EN), 32'd1);
        RUN_IN = 1'b0;
        for (int i = 0; i < 40 && STEP_EN !== 1'b0; i++) tick();
        chk("run_stop_en", 32'(STEP_EN), 32'd0);
        chk("run_stop_cnt", 32'(STEP_CNT), 32'(core_done));
        chk("run_stop_fetch", 32'(core_state), 32'h001);
        repeat (8) tick();
`endif

        // Halt from RUN; later steps must be ignored.
        RUN_IN = 1'b1;
        for (int i = 0; i < 30 && STEP_EN !== 1'b1; i++) tick();
        repeat (5) tick();
        force_state = 12'h800;
        force_en    = 1'b1;
        tick();
        chk("halt_halted", 32'(HALTED), 32'd1);
        chk("halt_step_en", 32'(STEP_EN), 32'd0);
        RUN_IN = 1'b0;
        repeat (10) tick();
        STEP_IN = 1'b1;
        hi_cnt = 0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (t == 5) STEP_IN = 1'b0;
            if (STEP_EN === 1'b1) hi_cnt++;
        end
        chk("halt_ignore_step", 32'(hi_cnt), 32'd0);
        chk("halt_sticky", 32'(HALTED), 32'd1);

        // Timeout, first with a reset pulse mid-wait, then to completion.
        do_reset("rst2");
        press(5);
        repeat (20) tick();
        chk("pre_tmo_cnt", 32'(STEP_CNT), 32'd1);
        force_state = 12'h002;
        force_en    = 1'b1;
        press(5);
        for (int i = 0; i < 30 && STEP_EN !== 1'b1; i++) tick();
        chk("tmo1_start", 32'(STEP_EN), 32'd1);
        repeat (300) tick();
        RESET_IN = 1'b1;
        tick();
        RESET_IN = 1'b0;
        chk_reset_vals("midrst");
        for (int i = 0; i < 20 && IN_INIT !== 1'b0; i++) tick();
        press(5);
        for (int i = 0; i < 30 && STEP_EN !== 1'b1; i++) tick();
        chk("tmo2_start", 32'(STEP_EN), 32'd1);
        repeat (1024) tick();
        chk("tmo_not_yet_err", 32'(ERR), 32'd0);
        chk("tmo_not_yet_en", 32'(STEP_EN), 32'd1);
        tick();
        chk("tmo_err", 32'(ERR), 32'd1);
        chk("tmo_step_en", 32'(STEP_EN), 32'd0);
        chk("tmo_cnt", 32'(STEP_CNT), 32'd0);
        repeat (5) tick();
        chk("tmo_err_sticky", 32'(ERR), 32'd1);

        do_reset("rst3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
